// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the memory port arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Request grant logic: LS wins by default, IF is forced after STARVE_LIMIT
// consecutive LS grants taken while IF was waiting.
module mem_arb_grant import mem_arb_pkg::*; #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             if_valid,
   input  logic             ls_valid,
   output logic             grant_if,
   output logic             grant_ls,
   output logic [CNT_W-1:0] starve_cnt
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (enable) begin
         if (if_valid && ls_valid) begin
            if (starve_cnt == LIMIT) grant_if = 1'b1;
            else                     grant_ls = 1'b1;
         end else if (if_valid) begin
            grant_if = 1'b1;
         end else if (ls_valid) begin
            grant_ls = 1'b1;
         end
      end
   end

   // Counts LS grants that overtook a waiting fetch; any other grant restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_if) begin
         starve_cnt <= '0;
      end else if (grant_ls) begin
         if (!if_valid)              starve_cnt <= '0;
         else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time, routing each response to its issuer.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   if_req_addr,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   output logic [DATA_W-1:0]   if_resp_data,
   output logic                if_resp_valid,
   input  logic                if_resp_ready,
   input  logic                if_flush,
   input  logic [ADDR_W-1:0]   ls_req_addr,
   input  logic [DATA_W-1:0]   ls_req_wdata,
   input  logic                ls_req_we,
   input  logic [DATA_W/8-1:0] ls_req_wstrb,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   output logic [DATA_W-1:0]   ls_resp_data,
   output logic                ls_resp_valid,
   input  logic                ls_resp_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic                mem_req_we,
   output logic [DATA_W/8-1:0] mem_req_wstrb,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   input  logic [DATA_W-1:0]   mem_resp_data,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready
);

   arb_state_t        state, state_next;
   owner_t            owner;
   logic              drop, drop_next;
   logic              grant_if, grant_ls;
   logic [CNT_W-1:0]  starve_cnt;
   logic [DATA_W-1:0] resp_data;
   logic              owner_flush;

   // Grant is only offered in IDLE and never while reset is held.
   mem_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
      .clk        (clk),
      .rst        (rst),
      .enable     (state == IDLE && !rst),
      .if_valid   (if_req_valid),
      .ls_valid   (ls_req_valid),
      .grant_if   (grant_if),
      .grant_ls   (grant_ls),
      .starve_cnt (starve_cnt)
   );

   assign owner_flush = (owner == OWN_IF) && if_flush;

   always_comb begin
      state_next = state;
      drop_next  = drop;
      case (state)
         IDLE: begin
            if (grant_if || grant_ls) state_next = ISSUE;
         end
         ISSUE: begin
            if (owner_flush)   drop_next  = 1'b1;
            if (mem_req_ready) state_next = WAIT;
         end
         WAIT: begin
            if (owner_flush) drop_next = 1'b1;
            // A fetch flushed while in flight is silently discarded here.
            if (mem_resp_valid) begin
               if (owner == OWN_IF && (drop || if_flush)) begin
                  state_next = IDLE;
                  drop_next  = 1'b0;
               end else begin
                  state_next = RESP;
               end
            end
         end
         RESP: begin
            if (owner == OWN_IF) begin
               if (if_flush || if_resp_ready) state_next = IDLE;
            end else if (ls_resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         owner         <= OWN_IF;
         drop          <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_we    <= 1'b0;
         mem_req_wstrb <= '0;
         resp_data     <= '0;
      end else begin
         state <= state_next;
         drop  <= drop_next;
         if (grant_if) begin
            owner         <= OWN_IF;
            mem_req_addr  <= if_req_addr;
            mem_req_wdata <= '0;
            mem_req_we    <= 1'b0;
            mem_req_wstrb <= '0;
         end else if (grant_ls) begin
            owner         <= OWN_LS;
            mem_req_addr  <= ls_req_addr;
            mem_req_wdata <= ls_req_wdata;
            mem_req_we    <= ls_req_we;
            mem_req_wstrb <= ls_req_wstrb;
         end
         if (state == WAIT && mem_resp_valid) resp_data <= mem_resp_data;
      end
   end

   assign if_req_ready   = grant_if;
   assign ls_req_ready   = grant_ls;
   assign mem_req_valid  = (state == ISSUE);
   assign mem_resp_ready = (state == WAIT);
   assign if_resp_valid  = (state == RESP) && (owner == OWN_IF);
   assign ls_resp_valid  = (state == RESP) && (owner == OWN_LS);
   assign if_resp_data   = resp_data;
   assign ls_resp_data   = resp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_req_addr;
   logic        if_req_valid, if_req_ready;
   logic [31:0] if_resp_data;
   logic        if_resp_valid, if_resp_ready, if_flush;
   logic [31:0] ls_req_addr, ls_req_wdata;
   logic        ls_req_we;
   logic [3:0]  ls_req_wstrb;
   logic        ls_req_valid, ls_req_ready;
   logic [31:0] ls_resp_data;
   logic        ls_resp_valid, ls_resp_ready;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic        mem_req_we;
   logic [3:0]  mem_req_wstrb;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_resp_data;
   logic        mem_resp_valid, mem_resp_ready;

   int num_checks = 0;
   int num_errors = 0;

   bit       exp_ls_grant[6] = '{1, 1, 1, 1, 0, 1};
   int       exp_cnt[6]      = '{0, 1, 2, 3, 4, 0};

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req_addr(if_req_addr), .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
      .if_resp_data(if_resp_data), .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
      .if_flush(if_flush),
      .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_we(ls_req_we),
      .ls_req_wstrb(ls_req_wstrb), .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
      .ls_resp_data(ls_resp_data), .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_we(mem_req_we),
      .mem_req_wstrb(mem_req_wstrb), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset with both requesters valid: nothing may be granted.
      rst = 1'b1;
      if_req_addr = '0; if_req_valid = 1'b1; if_resp_ready = 1'b0; if_flush = 1'b0;
      ls_req_addr = '0; ls_req_wdata = '0; ls_req_we = 1'b0; ls_req_wstrb = '0;
      ls_req_valid = 1'b1; ls_resp_ready = 1'b0;
      mem_req_ready = 1'b0; mem_resp_data = '0; mem_resp_valid = 1'b0;
      next_cycle(); next_cycle();
      @(negedge clk);
      checkOutput("rst_if_req_ready", if_req_ready, 0);
      checkOutput("rst_ls_req_ready", ls_req_ready, 0);
      checkOutput("rst_mem_req_valid", mem_req_valid, 0);
      checkOutput("rst_mem_resp_ready", mem_resp_ready, 0);
      checkOutput("rst_if_resp_valid", if_resp_valid, 0);
      checkOutput("rst_ls_resp_valid", ls_resp_valid, 0);
      checkOutput("rst_mem_req_addr", mem_req_addr, 0);
      checkOutput("rst_if_resp_data", if_resp_data, 0);
      checkOutput("rst_state", dut.state, IDLE);
      checkOutput("rst_starve_cnt", dut.starve_cnt, 0);
      next_cycle();
      rst = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0;

      // IF-only fetch at minimum turnaround.
      next_cycle();
      if_req_addr = 32'h0000_0100; if_req_valid = 1'b1;
      mem_req_ready = 1'b1; if_resp_ready = 1'b1; ls_resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("t1_if_req_ready", if_req_ready, 1);
      checkOutput("t1_ls_req_ready", ls_req_ready, 0);
      next_cycle();
      if_req_valid = 1'b0;
      @(negedge clk);
      checkOutput("t1_mem_req_valid", mem_req_valid, 1);
      checkOutput("t1_mem_req_addr", mem_req_addr, 32'h100);
      checkOutput("t1_mem_req_we", mem_req_we, 0);
      checkOutput("t1_mem_req_wstrb", mem_req_wstrb, 0);
      next_cycle();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
      @(negedge clk);
      checkOutput("t1_mem_resp_ready", mem_resp_ready, 1);
      next_cycle();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      checkOutput("t1_if_resp_valid", if_resp_valid, 1);
      checkOutput("t1_if_resp_data", if_resp_data, 32'h13);
      checkOutput("t1_ls_resp_valid", ls_resp_valid, 0);
      next_cycle();
      @(negedge clk);
      checkOutput("t1_if_resp_valid_done", if_resp_valid, 0);
      checkOutput("t1_state_idle", dut.state, IDLE);

      // Both requesters valid continuously: LS x4, then IF forced, then LS.
      next_cycle();
      if_req_addr = 32'h0000_1000; if_req_valid = 1'b1;
      ls_req_addr = 32'h0000_0200; ls_req_we = 1'b0; ls_req_valid = 1'b1;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222;
      for (int g = 0; g < 6; g++) begin
         int  waited;
         bit  was_ls;
         waited = 0;
         @(negedge clk);
         while (!(if_req_ready || ls_req_ready) && waited < 10) begin
            @(negedge clk);
            waited++;
         end
         checkOutput($sformatf("t2_grant_ls_%0d", g), ls_req_ready, exp_ls_grant[g]);
         checkOutput($sformatf("t2_grant_if_%0d", g), if_req_ready, !exp_ls_grant[g]);
         checkOutput($sformatf("t2_starve_cnt_%0d", g), dut.starve_cnt, exp_cnt[g]);
         was_ls = ls_req_ready;
         next_cycle();
         if (was_ls) ls_req_addr = ls_req_addr + 32'd4;
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      next_cycle(); next_cycle(); next_cycle();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      checkOutput("t2_state_idle", dut.state, IDLE);

      // Store with mem_req_ready held low for five cycles.
      next_cycle();
      mem_req_ready = 1'b0; ls_resp_ready = 1'b0;
      ls_req_addr = 32'h0000_0300; ls_req_wdata = 32'hDEAD_BEEF;
      ls_req_we = 1'b1; ls_req_wstrb = 4'hF; ls_req_valid = 1'b1;
      @(negedge clk);
      checkOutput("t3_ls_req_ready", ls_req_ready, 1);
      next_cycle();
      ls_req_valid = 1'b0; ls_req_addr = 32'hFFFF_FFFF; ls_req_wdata = '0;
      ls_req_we = 1'b0; ls_req_wstrb = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("t3_stall_valid", mem_req_valid, 1);
         checkOutput("t3_stall_addr", mem_req_addr, 32'h300);
         checkOutput("t3_stall_wdata", mem_req_wdata, 32'hDEAD_BEEF);
         checkOutput("t3_stall_we", mem_req_we, 1);
         checkOutput("t3_stall_wstrb", mem_req_wstrb, 4'hF);
         next_cycle();
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      checkOutput("t3_issue_valid", mem_req_valid, 1);
      next_cycle();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_5555;
      @(negedge clk);
      checkOutput("t3_wait_req_valid", mem_req_valid, 0);
      checkOutput("t3_wait_resp_ready", mem_resp_ready, 1);
      next_cycle();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      checkOutput("t3_ls_resp_valid", ls_resp_valid, 1);
      checkOutput("t3_if_resp_valid", if_resp_valid, 0);
      next_cycle();
      @(negedge clk);
      checkOutput("t3_ls_resp_hold", ls_resp_valid, 1);
      ls_resp_ready = 1'b1;
      next_cycle();
      @(negedge clk);
      checkOutput("t3_ls_resp_done", ls_resp_valid, 0);
      checkOutput("t3_starve_cnt", dut.starve_cnt, 0);

      // Fetch flushed during WAIT: memory completes, no IF response.
      next_cycle();
      if_req_addr = 32'h0000_0400; if_req_valid = 1'b1; if_resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("t4_if_req_ready", if_req_ready, 1);
      next_cycle();
      if_req_valid = 1'b0;
      next_cycle();
      if_flush = 1'b1;
      @(negedge clk);
      checkOutput("t4_wait_resp_ready", mem_resp_ready, 1);
      next_cycle();
      if_flush = 1'b0;
      @(negedge clk);
      checkOutput("t4_drop_set", dut.drop, 1);
      checkOutput("t4_if_resp_valid_wait", if_resp_valid, 0);
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0BAD;
      next_cycle();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      checkOutput("t4_state_idle", dut.state, IDLE);
      checkOutput("t4_if_resp_valid", if_resp_valid, 0);
      checkOutput("t4_drop_clear", dut.drop, 0);

      // Fetch response stalled by if_resp_ready low for three cycles.
      next_cycle();
      if_req_addr = 32'h0000_0500; if_req_valid = 1'b1; if_resp_ready = 1'b0;
      next_cycle();
      if_req_valid = 1'b0;
      @(negedge clk);
      checkOutput("t5_mem_req_addr", mem_req_addr, 32'h500);
      next_cycle();
      mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
      next_cycle();
      mem_resp_valid = 1'b0; mem_resp_data = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("t5_stall_valid", if_resp_valid, 1);
         checkOutput("t5_stall_data", if_resp_data, 32'hCAFE_F00D);
         next_cycle();
      end
      if_resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("t5_resp_valid", if_resp_valid, 1);
      next_cycle();
      @(negedge clk);
      checkOutput("t5_resp_done", if_resp_valid, 0);

      // Flush while the fetch response is being presented.
      next_cycle();
      if_req_addr = 32'h0000_0600; if_req_valid = 1'b1; if_resp_ready = 1'b0;
      next_cycle();
      if_req_valid = 1'b0;
      next_cycle();
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0077;
      next_cycle();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      checkOutput("t6_if_resp_valid", if_resp_valid, 1);
      if_flush = 1'b1;
      next_cycle();
      if_flush = 1'b0;
      @(negedge clk);
      checkOutput("t6_flush_resp_valid", if_resp_valid, 0);
      checkOutput("t6_state_idle", dut.state, IDLE);

      // Reset during WAIT abandons the load and clears the starvation count.
      next_cycle();
      if_req_addr = 32'h0000_0800; if_req_valid = 1'b1;
      ls_req_addr = 32'h0000_0700; ls_req_we = 1'b0; ls_req_valid = 1'b1;
      ls_resp_ready = 1'b1; if_resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("t7_ls_req_ready", ls_req_ready, 1);
      next_cycle();
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      checkOutput("t7_wait_resp_ready", mem_resp_ready, 1);
      checkOutput("t7_starve_cnt_pre", dut.starve_cnt, 1);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t7_state_idle", dut.state, IDLE);
      checkOutput("t7_starve_cnt", dut.starve_cnt, 0);
      checkOutput("t7_mem_resp_ready", mem_resp_ready, 0);
      checkOutput("t7_mem_req_valid", mem_req_valid, 0);
      checkOutput("t7_ls_resp_valid", ls_resp_valid, 0);
      checkOutput("t7_if_resp_valid", if_resp_valid, 0);
      checkOutput("t7_mem_req_addr", mem_req_addr, 0);

      $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
      $finish;
   end

endmodule
